uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of uart_tx, sharing its MAIN_CLK/BAUD parameterisation.
- Synchronises the asynchronous rx line, detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit.
- Presents each good byte on a valid/ready output port backed by a one-entry holding register.
- Sits between the board RX pin and downstream byte consumers (command parser, loopback FIFO).

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchroniser, mid-bit
// sampling, stop-bit check and a one-entry valid/ready output holding register.
module uart_rx #(
  parameter int MAIN_CLK = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB  = MAIN_CLK / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx: MAIN_CLK/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic          rx_s1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          slot_free;

  // A pending byte may be replaced when it is being consumed on this same edge.
  assign slot_free = !data_out_valid || data_out_ready;
  assign busy      = (state != S_IDLE);

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s  <= rx_s1;
    end
  end

  // Frame FSM, bit timing, shift register and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      // A transfer drains the slot; a load in STOP below overrides this.
      if (data_out_valid && data_out_ready)
        data_out_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= HALF_M1;
          end
        end

        S_START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state   <= S_DATA;
              cnt     <= CPB_M1;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == '0) begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= CPB_M1;
            if (bit_idx == 3'd7)
              state <= S_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= S_IDLE;
              if (slot_free) begin
                data_out       <= shift;
                data_out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (rx_s)
            state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CPB=4.
module tb_uart_rx;

  localparam int MAIN_CLK = 4;
  localparam int BAUD     = 1;
  localparam int CPB      = MAIN_CLK / BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       fe;
  logic       ov;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(
    .MAIN_CLK(MAIN_CLK),
    .BAUD    (BAUD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data_out      (data_out),
    .data_out_valid(valid),
    .data_out_ready(ready),
    .framing_error (fe),
    .overrun       (ov),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Observe transfers and pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) got_q.push_back(data_out);
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame; caller is just after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_stream(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vt[7];
  int   rise;
  int   fe0;
  int   ov0;
  int   exp_fe;
  logic [7:0] b;
  logic       s;

  initial begin
    //          data   stop  rdy  valid  data   fe ov
    vt[0] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0};
    vt[1] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 0, 1};
    vt[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h11, 1, 0};
    vt[3] = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A, 0, 0};
    vt[4] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 0, 0};
    vt[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'hC3, 1, 0};
    vt[6] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", data_out, 0);
    check("rst_fe", fe, 0);
    check("rst_ov", ov, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(4);

    // Latency: valid must appear 40 cycles after the start bit's first edge
    fe0 = fe_cnt; ov0 = ov_cnt; rise = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (valid && rise < 0) rise = c;
        end
      end
    join
    @(posedge clk); #1;
    check("timing_latency", rise, 40);
    check("timing_data", data_out, 8'hA5);
    check("timing_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    ready = 1'b1; @(posedge clk); #1; ready = 1'b0;
    check("timing_drain", valid, 0);
    got_q.delete();

    // Glitch: one low cycle is rejected at mid start bit
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0; @(posedge clk); #1;
    rx = 1'b1; @(posedge clk); #1;
    @(posedge clk); #1;
    check("glitch_busy_start", busy, 1);
    repeat (3) @(posedge clk); #1;
    check("glitch_busy_end", busy, 0);
    idle(40);
    check("glitch_valid", valid, 0);
    check("glitch_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Framing error then held-low break, then recovery
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (50) @(posedge clk); #1;
    check("frame_fe_pulses", fe_cnt - fe0, 1);
    check("frame_busy_low", busy, 1);
    check("frame_valid", valid, 0);
    idle(4);
    check("frame_busy_released", busy, 0);
    send_frame(8'h55, 1'b1);
    idle(4);
    check("frame_recover_valid", valid, 1);
    check("frame_recover_data", data_out, 8'h55);
    ready = 1'b1; @(posedge clk); #1; ready = 1'b0;
    got_q.delete();

    // Table of frames against the holding register
    for (int i = 0; i < 7; i++) begin
      fe0 = fe_cnt; ov0 = ov_cnt;
      ready = vt[i].rdy;
      send_frame(vt[i].data, vt[i].stop);
      idle(6);
      check($sformatf("vec%0d_valid", i), valid, vt[i].exp_valid);
      check($sformatf("vec%0d_data", i), data_out, vt[i].exp_data);
      check($sformatf("vec%0d_fe", i), fe_cnt - fe0, vt[i].exp_fe);
      check($sformatf("vec%0d_ov", i), ov_cnt - ov0, vt[i].exp_ov);
    end
    ready = 1'b0;
    got_q.delete();

    // Drain and load on the same stop-sample edge
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    idle(2);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (40) @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
      end
    join
    idle(3);
    check("simul_drained_count", got_q.size(), 1);
    if (got_q.size() > 0) check("simul_drained_byte", got_q[0], 8'h11);
    check("simul_data", data_out, 8'h22);
    check("simul_valid", valid, 1);
    check("simul_ov", ov_cnt - ov0, 0);

    // Reset mid-frame clears everything at once
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (16) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", valid, 0);
        check("rst_mid_data", data_out, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pulses", {fe, ov}, 0);
      end
    join
    idle(4);
    rst_n = 1'b1;
    idle(4);
    got_q.delete();
    exp_q.delete();
    ready = 1'b1;
    send_frame(8'h7E, 1'b1);
    idle(4);
    exp_q.push_back(8'h7E);
    compare_stream("after_reset");

    // Streaming: counting pattern back-to-back, then random frames and gaps
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt; exp_fe = 0;
    for (int r = 0; r < 2; r++)
      for (int v = 8'h41; v <= 8'h57; v++) begin
        send_frame(8'(v), 1'b1);
        exp_q.push_back(8'(v));
      end
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 5) != 0);
      send_frame(b, s);
      if (s) exp_q.push_back(b);
      else exp_fe++;
      idle((s ? 0 : 1) + $urandom_range(0, 3));
    end
    idle(10);
    compare_stream("stream");
    check("stream_fe", fe_cnt - fe0, exp_fe);
    check("stream_ov", ov_cnt - ov0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
